// File: rtl/alu_operand_stage_pkg.sv
// Shared widths, ALU control codes and operand-select encodings for the
// ID/EX operand stage.
package alu_operand_stage_pkg;

    localparam int REG_W      = 32;
    localparam int ALUC_BUS_W = 4;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_W-1:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [ALUC_BUS_W-1:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_XOR = 4'd2,
        ALU_NOR = 4'd3,
        ALU_ADD = 4'd4,
        ALU_SUB = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9,
        ALU_LUI = 4'd10
    } alu_op_e;

    localparam logic       A_SEL_RS    = 1'b0;
    localparam logic       A_SEL_SHAMT = 1'b1;

    localparam logic [1:0] B_SEL_RT    = 2'd0;
    localparam logic [1:0] B_SEL_SIMM  = 2'd1;
    localparam logic [1:0] B_SEL_ZIMM  = 2'd2;
    localparam logic [1:0] B_SEL_RSVD  = 2'd3;

endpackage

// File: rtl/alu_operand_stage_operand_forward_mux.sv
// Forwarding select for one source register: f1 beats f2 beats register file,
// and register 0 is never forwarded.
module operand_forward_mux #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic [RA_W-1:0]   addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              f1_wr_en,
    input  logic [RA_W-1:0]   f1_wr_addr,
    input  logic [DATA_W-1:0] f1_data,
    input  logic              f2_wr_en,
    input  logic [RA_W-1:0]   f2_wr_addr,
    input  logic [DATA_W-1:0] f2_data,
    output logic [DATA_W-1:0] data,
    output logic              f1_hit
);

    logic nonzero;
    logic f2_hit;

    assign nonzero = (addr != {RA_W{1'b0}});
    assign f1_hit  = nonzero && f1_wr_en && (f1_wr_addr == addr);
    assign f2_hit  = nonzero && f2_wr_en && (f2_wr_addr == addr);

    // Priority select of the forwarded value
    always_comb begin
        data = rf_data;
        if (f1_hit) begin
            data = f1_data;
        end else if (f2_hit) begin
            data = f2_data;
        end else begin
            data = rf_data;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register feeding the ALU: operand select, two-level forwarding,
// load-use bubble insertion, valid/ready handshake and flush.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int ALUC_W = ALUC_BUS_W,
    parameter int RA_W   = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ALUC_W-1:0] in_aluc,
    input  logic [RA_W-1:0]   in_rs_addr,
    input  logic [RA_W-1:0]   in_rt_addr,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [15:0]       in_imm16,
    input  logic [4:0]        in_shamt,
    input  logic              in_a_sel,
    input  logic [1:0]        in_b_sel,
    input  logic              in_wr_en,
    input  logic [RA_W-1:0]   in_wr_addr,
    input  logic              in_is_load,
    input  logic              f1_wr_en,
    input  logic [RA_W-1:0]   f1_wr_addr,
    input  logic [DATA_W-1:0] f1_data,
    input  logic              f1_pending,
    input  logic              f2_wr_en,
    input  logic [RA_W-1:0]   f2_wr_addr,
    input  logic [DATA_W-1:0] f2_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ALUC_W-1:0] out_aluc,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              out_wr_en,
    output logic [RA_W-1:0]   out_wr_addr,
    output logic              out_is_load,
    output logic              hazard_stall
);

    logic [DATA_W-1:0] a_fwd;
    logic [DATA_W-1:0] b_fwd;
    logic              a_f1_hit;
    logic              b_f1_hit;
    logic              rs_used;
    logic              rt_used;
    logic              capture;
    logic [DATA_W-1:0] a_op;
    logic [DATA_W-1:0] b_op;

    operand_forward_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_a (
        .addr       (in_rs_addr),
        .rf_data    (in_rs_data),
        .f1_wr_en   (f1_wr_en),
        .f1_wr_addr (f1_wr_addr),
        .f1_data    (f1_data),
        .f2_wr_en   (f2_wr_en),
        .f2_wr_addr (f2_wr_addr),
        .f2_data    (f2_data),
        .data       (a_fwd),
        .f1_hit     (a_f1_hit)
    );

    operand_forward_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_b (
        .addr       (in_rt_addr),
        .rf_data    (in_rt_data),
        .f1_wr_en   (f1_wr_en),
        .f1_wr_addr (f1_wr_addr),
        .f1_data    (f1_data),
        .f2_wr_en   (f2_wr_en),
        .f2_wr_addr (f2_wr_addr),
        .f2_data    (f2_data),
        .data       (b_fwd),
        .f1_hit     (b_f1_hit)
    );

    // The reserved b_sel code behaves like rt so it still participates in hazards
    assign rs_used      = (in_a_sel == A_SEL_RS);
    assign rt_used      = (in_b_sel == B_SEL_RT) || (in_b_sel == B_SEL_RSVD);
    assign hazard_stall = in_valid && f1_pending &&
                          ((rs_used && a_f1_hit) || (rt_used && b_f1_hit));
    assign in_ready     = !hazard_stall && (!out_valid || out_ready);
    assign capture      = in_valid && in_ready;

    // Operand selection for the ALU a and b inputs
    always_comb begin
        a_op = a_fwd;
        b_op = b_fwd;
        if (in_a_sel == A_SEL_SHAMT) begin
            a_op = {{(DATA_W-5){1'b0}}, in_shamt};
        end else begin
            a_op = a_fwd;
        end
        case (in_b_sel)
            B_SEL_SIMM: b_op = {{(DATA_W-16){in_imm16[15]}}, in_imm16};
            B_SEL_ZIMM: b_op = {{(DATA_W-16){1'b0}}, in_imm16};
            default:    b_op = b_fwd;
        endcase
    end

    // Pipeline register; out_wr_en is forced low whenever the slot empties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_aluc    <= {ALUC_W{1'b0}};
            out_a       <= {DATA_W{1'b0}};
            out_b       <= {DATA_W{1'b0}};
            out_wr_en   <= 1'b0;
            out_wr_addr <= {RA_W{1'b0}};
            out_is_load <= 1'b0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            out_wr_en   <= 1'b0;
            out_is_load <= 1'b0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_aluc    <= in_aluc;
            out_a       <= a_op;
            out_b       <= b_op;
            out_wr_en   <= in_wr_en;
            out_wr_addr <= in_wr_addr;
            out_is_load <= in_is_load;
        end else if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
            out_wr_en   <= 1'b0;
        end else begin
            out_valid   <= out_valid;
            out_wr_en   <= out_wr_en;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed and randomized checks of alu_operand_stage against a behavioural
// model of the stage's forwarding, hazard and handshake rules.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [3:0]  in_aluc;
    logic [4:0]  in_rs_addr, in_rt_addr, in_wr_addr, f1_wr_addr, f2_wr_addr, out_wr_addr;
    logic [31:0] in_rs_data, in_rt_data, f1_data, f2_data, out_a, out_b;
    logic [15:0] in_imm16;
    logic [4:0]  in_shamt;
    logic        in_a_sel;
    logic [1:0]  in_b_sel;
    logic        in_wr_en, in_is_load, f1_wr_en, f1_pending, f2_wr_en;
    logic        out_valid, out_ready, out_wr_en, out_is_load, hazard_stall;
    logic [3:0]  out_aluc;

    int checks = 0;
    int errors = 0;

    // model state
    logic        m_valid, m_wr_en, m_is_load;
    logic [3:0]  m_aluc;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_wr_addr;
    logic        obs_hz, obs_rdy;

    alu_operand_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_aluc(in_aluc),
        .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .in_imm16(in_imm16), .in_shamt(in_shamt),
        .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
        .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_is_load(in_is_load),
        .f1_wr_en(f1_wr_en), .f1_wr_addr(f1_wr_addr), .f1_data(f1_data), .f1_pending(f1_pending),
        .f2_wr_en(f2_wr_en), .f2_wr_addr(f2_wr_addr), .f2_data(f2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_aluc(out_aluc),
        .out_a(out_a), .out_b(out_b),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_is_load(out_is_load),
        .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic f1_match(input logic [4:0] r);
        return (r != 5'd0) && f1_wr_en && (f1_wr_addr == r);
    endfunction

    function automatic logic [31:0] reg_value(input logic [4:0] r, input logic [31:0] rf);
        if (r != 5'd0 && f1_wr_en && f1_wr_addr == r) return f1_data;
        if (r != 5'd0 && f2_wr_en && f2_wr_addr == r) return f2_data;
        return rf;
    endfunction

    function automatic logic [31:0] exp_a();
        return in_a_sel ? {27'd0, in_shamt} : reg_value(in_rs_addr, in_rs_data);
    endfunction

    function automatic logic [31:0] exp_b();
        if (in_b_sel == 2'd1) return {{16{in_imm16[15]}}, in_imm16};
        if (in_b_sel == 2'd2) return {16'h0000, in_imm16};
        return reg_value(in_rt_addr, in_rt_data);
    endfunction

    task automatic model_clear();
        m_valid = 1'b0; m_wr_en = 1'b0; m_is_load = 1'b0;
        m_aluc = 4'd0; m_a = 32'd0; m_b = 32'd0; m_wr_addr = 5'd0;
    endtask

    task automatic compare_outputs(input string tag);
        check({tag, "_valid"},   {63'd0, out_valid},   {63'd0, m_valid});
        check({tag, "_wr_en"},   {63'd0, out_wr_en},   {63'd0, m_wr_en});
        check({tag, "_is_load"}, {63'd0, out_is_load}, {63'd0, m_is_load});
        check({tag, "_aluc"},    {60'd0, out_aluc},    {60'd0, m_aluc});
        check({tag, "_a"},       {32'd0, out_a},       {32'd0, m_a});
        check({tag, "_b"},       {32'd0, out_b},       {32'd0, m_b});
        check({tag, "_wr_addr"}, {59'd0, out_wr_addr}, {59'd0, m_wr_addr});
    endtask

    // Inputs are already applied; check handshake, clock once, check outputs.
    task automatic cycle(input string tag);
        logic hz, rdy, cap;
        logic [31:0] ea, eb;
        #1;
        hz  = in_valid && f1_pending &&
              ((!in_a_sel && f1_match(in_rs_addr)) ||
               ((in_b_sel == 2'd0 || in_b_sel == 2'd3) && f1_match(in_rt_addr)));
        rdy = !hz && (!m_valid || out_ready);
        cap = in_valid && rdy;
        ea  = exp_a();
        eb  = exp_b();
        obs_hz  = hazard_stall;
        obs_rdy = in_ready;
        check({tag, "_hazard"},   {63'd0, hazard_stall}, {63'd0, hz});
        check({tag, "_in_ready"}, {63'd0, in_ready},     {63'd0, rdy});
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0; m_wr_en = 1'b0; m_is_load = 1'b0;
        end else if (cap) begin
            m_valid = 1'b1; m_aluc = in_aluc; m_a = ea; m_b = eb;
            m_wr_en = in_wr_en; m_wr_addr = in_wr_addr; m_is_load = in_is_load;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0; m_wr_en = 1'b0;
        end
        #1;
        compare_outputs(tag);
    endtask

    task automatic idle();
        flush = 1'b0; in_valid = 1'b0; in_aluc = 4'd0;
        in_rs_addr = 5'd0; in_rt_addr = 5'd0; in_rs_data = 32'd0; in_rt_data = 32'd0;
        in_imm16 = 16'd0; in_shamt = 5'd0; in_a_sel = 1'b0; in_b_sel = 2'd0;
        in_wr_en = 1'b0; in_wr_addr = 5'd0; in_is_load = 1'b0;
        f1_wr_en = 1'b0; f1_wr_addr = 5'd0; f1_data = 32'd0; f1_pending = 1'b0;
        f2_wr_en = 1'b0; f2_wr_addr = 5'd0; f2_data = 32'd0;
        out_ready = 1'b1;
    endtask

    task automatic instr(input logic [3:0] op, input logic [4:0] rs, input logic [31:0] rsd,
                         input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd);
        in_valid = 1'b1; in_aluc = op; in_rs_addr = rs; in_rs_data = rsd;
        in_rt_addr = rt; in_rt_data = rtd; in_wr_en = 1'b1; in_wr_addr = rd;
        in_a_sel = 1'b0; in_b_sel = 2'd0; in_is_load = 1'b0;
    endtask

    // Reset asserted mid-cycle must clear the outputs without waiting for an edge.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        model_clear();
        compare_outputs(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare_outputs({tag, "_rel"});
    endtask

    initial begin
        logic [31:0] held_a;
        rst = 1'b1;
        idle();
        model_clear();
        #3;
        pulse_reset("reset");

        // add r3 = r1 + r2
        instr(ALU_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
        cycle("add");
        check("add_a_const", {32'd0, out_a}, 64'd5);
        check("add_b_const", {32'd0, out_b}, 64'd7);
        check("add_aluc_const", {60'd0, out_aluc}, {60'd0, 4'd4});
        check("add_valid_const", {63'd0, out_valid}, 64'd1);

        instr(ALU_ADD, 5'd1, 32'd1, 5'd0, 32'd0, 5'd4);
        in_b_sel = 2'd1; in_imm16 = 16'hFFFE;
        cycle("addi_s");
        check("addi_s_const", {32'd0, out_b}, 64'hFFFF_FFFE);
        in_b_sel = 2'd2;
        cycle("addi_z");
        check("addi_z_const", {32'd0, out_b}, 64'h0000_FFFE);
        instr(ALU_SLL, 5'd0, 32'd0, 5'd2, 32'd9, 5'd5);
        in_a_sel = 1'b1; in_shamt = 5'd4;
        cycle("sll");
        check("sll_a_const", {32'd0, out_a}, 64'd4);

        // forwarding priority and the r0 exception
        instr(ALU_OR, 5'd8, 32'h1111, 5'd2, 32'd3, 5'd6);
        f1_wr_en = 1'b1; f1_wr_addr = 5'd8; f1_data = 32'hAAAA;
        f2_wr_en = 1'b1; f2_wr_addr = 5'd8; f2_data = 32'hBBBB;
        cycle("fwd_f1");
        check("fwd_f1_const", {32'd0, out_a}, 64'hAAAA);
        f1_wr_en = 1'b0;
        cycle("fwd_f2");
        check("fwd_f2_const", {32'd0, out_a}, 64'hBBBB);
        in_rs_addr = 5'd0; in_rs_data = 32'h55; f1_wr_en = 1'b1; f1_wr_addr = 5'd0;
        f2_wr_addr = 5'd0;
        cycle("fwd_r0");
        check("fwd_r0_const", {32'd0, out_a}, 64'h55);

        // load-use hazard then release
        idle();
        instr(ALU_ADD, 5'd1, 32'd2, 5'd9, 32'hDEAD, 5'd7);
        f1_wr_en = 1'b1; f1_wr_addr = 5'd9; f1_pending = 1'b1; f1_data = 32'hFFFF;
        cycle("lu_stall");
        check("lu_hz_const", {63'd0, obs_hz}, 64'd1);
        check("lu_rdy_const", {63'd0, obs_rdy}, 64'd0);
        check("lu_bubble_const", {63'd0, out_valid}, 64'd0);
        check("lu_bubble_wr_const", {63'd0, out_wr_en}, 64'd0);
        f1_pending = 1'b0; f1_data = 32'h1234;
        cycle("lu_go");
        check("lu_go_const", {32'd0, out_b}, 64'h1234);

        // backpressure for three cycles
        idle();
        instr(ALU_SUB, 5'd1, 32'h77, 5'd2, 32'h11, 5'd3);
        cycle("bp_fill");
        held_a = out_a;
        instr(ALU_XOR, 5'd4, 32'h99, 5'd5, 32'h22, 5'd6);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold");
            check("bp_rdy_const", {63'd0, obs_rdy}, 64'd0);
            check("bp_stable", {32'd0, out_a}, {32'd0, held_a});
        end
        out_ready = 1'b1;
        cycle("bp_release");
        check("bp_release_const", {32'd0, out_a}, 64'h99);

        // flush with a valid held instruction and a valid incoming one
        instr(ALU_AND, 5'd7, 32'h3C, 5'd8, 32'h0F, 5'd9);
        flush = 1'b1;
        cycle("flush");
        check("flush_valid_const", {63'd0, out_valid}, 64'd0);
        check("flush_wr_const", {63'd0, out_wr_en}, 64'd0);
        flush = 1'b0;
        cycle("post_flush");
        out_ready = 1'b0;
        in_aluc = ALU_NOR;
        cycle("pre_rst");
        pulse_reset("rst_mid");
        idle();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_aluc    = 4'($urandom_range(0, 10));
            in_rs_addr = 5'($urandom_range(0, 3));
            in_rt_addr = 5'($urandom_range(0, 3));
            in_rs_data = $urandom; in_rt_data = $urandom;
            in_imm16   = 16'($urandom); in_shamt = 5'($urandom);
            in_a_sel   = ($urandom_range(0, 3) == 0);
            in_b_sel   = 2'($urandom_range(0, 3));
            in_wr_en   = 1'($urandom); in_wr_addr = 5'($urandom); in_is_load = 1'($urandom);
            f1_wr_en   = 1'($urandom); f1_wr_addr = 5'($urandom_range(0, 3));
            f1_data    = $urandom; f1_pending = ($urandom_range(0, 3) == 0);
            f2_wr_en   = 1'($urandom); f2_wr_addr = 5'($urandom_range(0, 3));
            f2_data    = $urandom;
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 19) == 0);
            cycle("rand");
            if (!out_valid) check("rand_idle_wr", {63'd0, out_wr_en}, 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline register that sits directly upstream of the ALU and produces its aluc, a and b inputs.
- Selects the ALU operands: register value, sign- or zero-extended immediate, or shift amount.
- Applies two-level result forwarding and detects load-use hazards, inserting a bubble when one occurs.
- Moves instructions with a single-entry valid/ready handshake and supports flush.

Parameters:
- DATA_W, 32, operand/result width (RegBus)
- ALUC_W, 4, ALU control width (ALUCtrlBus)
- RA_W, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- flush  in  1  kill held and incoming instruction (branch/exception)
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_aluc  in  ALUC_W  ALU operation
- in_rs_addr, in_rt_addr  in  RA_W  source register numbers
- in_rs_data, in_rt_data  in  DATA_W  register-file read data
- in_imm16  in  16  instruction immediate
- in_shamt  in  5  instruction shamt field
- in_a_sel  in  1  0=rs data, 1=zero-extended shamt
- in_b_sel  in  2  0=rt data, 1=sign-extended imm, 2=zero-extended imm, 3=reserved (treated as 0)
- in_wr_en, in_wr_addr, in_is_load  in  1/RA_W/1  destination info, carried through
- f1_wr_en, f1_wr_addr, f1_data, f1_pending  in  1/RA_W/DATA_W/1  nearer forward source; pending=1 means load data not yet available
- f2_wr_en, f2_wr_addr, f2_data  in  1/RA_W/DATA_W  farther forward source (write-back)
- out_valid  out  1  ALU inputs valid
- out_ready  in  1  ALU/EX accepts
- out_aluc  out  ALUC_W  to ALU aluc
- out_a, out_b  out  DATA_W  to ALU a, b
- out_wr_en, out_wr_addr, out_is_load  out  1/RA_W/1  carried destination info
- hazard_stall  out  1  load-use bubble being inserted (combinational)

Behaviour:
- Reset: asynchronous on rst high; all outputs registered to 0, including out_valid=0.
- Operand use:
  - rs is used iff in_a_sel=0.
  - rt is used iff in_b_sel is 0 or 3.
  - Register 0 never matches a forward source.
- Forwarding, per used operand:
  - f1 match (f1_wr_en and addr equal): f1_data.
  - Else f2 match: f2_data.
  - Else register-file data.
  - f1 has priority over f2.
- Hazard: hazard_stall = in_valid and a used operand matches f1 and f1_pending.
- in_ready = !hazard_stall && (!out_valid || out_ready).
- Capture on edge when in_valid && in_ready:
  - Outputs load the selected operands, in_aluc and destination info.
  - out_valid is set to 1.
- Operand encodings:
  - Shamt on a: {27'b0, in_shamt}.
  - Sign-extended imm: {16{imm[15]}, imm}.
  - Zero-extended imm: {16'b0, imm}.
  - lui needs b = immediate; decode selects b_sel=2.
- out_ready && out_valid with no capture: out_valid goes to 0. This is a bubble, and other out_* hold their values.
- Hazard stall with the held instruction consumed: a bubble is inserted (out_valid=0 next cycle) and decode holds its inputs.
- out_valid && !out_ready: all outputs hold and in_ready=0.
- Flush (highest priority): at the next edge out_valid=0, out_wr_en=0 and out_is_load=0. No capture that cycle, even if in_valid && in_ready.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 instruction/cycle when out_ready stays 1.
- rst mid-stall or mid-flush: immediately empty.
- While out_valid=0, out_wr_en must read 0 so that no bogus write can occur downstream.

Decomposition:
- Shared package/header (defines.vh):
  - ALU_* opcodes, ALUCtrlBus, RegBus, ZeroWord.
  - New A_SEL_*/B_SEL_* encodings and RegAddrBus.
- One sub-module, operand_forward_mux: combinational match, priority and select for one operand. It is instantiated twice (a and b).
- The pipeline register and hazard logic stay in the top module.

Test Plan:
- Reset then add r3=r1+r2 with rs=5, rt=7 and no forwards -> one cycle later out_valid=1, out_a=5, out_b=7, out_aluc=ALU_add.
- addi with imm16=16'hFFFE, b_sel=1 -> out_b=32'hFFFFFFFE. Same with b_sel=2 -> 32'h0000FFFE. sll with shamt=4, a_sel=1 -> out_a=4.
- rs=r8, f1 wr r8 data 0xAAAA, f2 wr r8 data 0xBBBB -> out_a=0xAAAA. Repeat with rs=r0 and f1 addr 0 -> register-file value.
- Load-use: rt=r9, f1 wr r9 pending=1 -> hazard_stall=1, in_ready=0 and a bubble (out_valid=0). Next cycle pending=0 with f1_data=0x1234 -> captured with out_b=0x1234.
- out_ready=0 for 3 cycles while in_valid=1 -> outputs stable and in_ready=0. Release -> the next instruction is captured on the next edge.
- Flush asserted with in_valid=1 and out_valid=1 -> next cycle out_valid=0 and out_wr_en=0, and the incoming instruction is not captured. rst pulsed mid-transfer -> immediate zeroing.
